imm_decode_stage: RTL

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_pkg.sv | 39 +++
 rtl/imm_format_decode.sv | 76 +++++++
 rtl/imm_decode_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate decode stage: format codes, RISC-V major opcodes
// and the XLEN legality check.
package imm_pkg;

    typedef enum logic [2:0] {
        FmtI    = 3'd0,
        FmtS    = 3'd1,
        FmtB    = 3'd2,
        FmtU    = 3'd3,
        FmtJ    = 3'd4,
        FmtZ    = 3'd5,
        FmtR    = 3'd6,
        FmtNone = 3'd7
    } fmt_e;

    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    // Width-independent part of a buffered entry; the immediate is stored alongside.
    typedef struct packed {
        logic [31:0] instr;
        fmt_e        fmt;
        logic        illegal;
    } meta_t;

    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_format_decode.sv
// Combinational opcode-to-format decode and immediate extraction/extension to XLEN bits.
import imm_pkg::*;

module imm_format_decode #(
    parameter int unsigned XLEN            = 32,
    parameter bit          FMT_OVERRIDE_EN = 1'b0
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      fmt_ovr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    fmt_e        dec_fmt;
    logic        dec_illegal;
    fmt_e        fmt;
    logic [31:0] imm32;
    logic        ext_bit;

    always_comb begin
        dec_fmt     = FmtNone;
        dec_illegal = 1'b0;
        case (instr_i[6:0])
            OpcOpImm, OpcLoad, OpcJalr, OpcMiscMem: dec_fmt = FmtI;
            OpcStore:                               dec_fmt = FmtS;
            OpcBranch:                              dec_fmt = FmtB;
            OpcLui, OpcAuipc:                       dec_fmt = FmtU;
            OpcJal:                                 dec_fmt = FmtJ;
            OpcOp:                                  dec_fmt = FmtR;
            OpcSystem:                              dec_fmt = instr_i[14] ? FmtZ : FmtI;
            default: begin
                dec_fmt     = FmtNone;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (FMT_OVERRIDE_EN) begin
            fmt       = fmt_e'(fmt_ovr_i);
            illegal_o = (fmt_ovr_i == 3'd7);
        end else begin
            fmt       = dec_fmt;
            illegal_o = dec_illegal;
        end
    end

    assign fmt_o = fmt;

    // Every signed format (U included) has instr[31] as bit 31, so one fill covers XLEN=64.
    always_comb begin
        imm32   = '0;
        ext_bit = instr_i[31];
        case (fmt)
            FmtI: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            FmtS: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FmtB: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            FmtU: imm32 = {instr_i[31:12], 12'b0};
            FmtJ: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            FmtZ: begin
                imm32   = {27'b0, instr_i[19:15]};
                ext_bit = 1'b0;
            end
            default: begin
                imm32   = '0;
                ext_bit = 1'b0;
            end
        endcase
        imm_o        = {XLEN{ext_bit}};
        imm_o[31:0]  = imm32;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes on entry and holds results in a two-entry skid buffer
// (output register plus skid register) with a registered in_ready.
import imm_pkg::*;

module imm_decode_stage #(
    parameter int unsigned XLEN            = 32,
    parameter bit          FMT_OVERRIDE_EN = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_fmt_ovr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    meta_t           dec_meta;

    imm_format_decode #(
        .XLEN            (XLEN),
        .FMT_OVERRIDE_EN (FMT_OVERRIDE_EN)
    ) u_decode (
        .instr_i   (in_instr),
        .fmt_ovr_i (in_fmt_ovr),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        dec_meta.instr   = in_instr;
        dec_meta.fmt     = fmt_e'(dec_fmt);
        dec_meta.illegal = dec_illegal;
    end

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    meta_t           out_meta_q, out_meta_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    meta_t           skid_meta_q, skid_meta_d;
    logic            accept;
    logic            out_free;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;
    // Output register can be loaded this cycle when empty or being drained.
    assign out_free = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_meta_d   = out_meta_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_meta_d  = skid_meta_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_meta_d   = skid_meta_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_meta_d  = dec_meta;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_meta_d  = dec_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_meta_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_meta_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_meta_q   <= out_meta_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_meta_q  <= skid_meta_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_meta_q.fmt;
    assign out_illegal = out_meta_q.illegal;
    assign out_instr   = out_meta_q.instr;

endmodule
